// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU arbiter slice:
// opcodes, controller state encoding and default widths.
package alu_ctrl_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int OP_W_DEF   = 3;

    localparam logic [OP_W_DEF-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W_DEF-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W_DEF-1:0] OP_AND = 3'b010;
    localparam logic [OP_W_DEF-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W_DEF-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W_DEF-1:0] OP_NOT = 3'b101;
    localparam logic [OP_W_DEF-1:0] OP_SHL = 3'b110;
    localparam logic [OP_W_DEF-1:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/alu_4bit.sv
// Combinational 4-bit ALU shared by the arbiter's clients.
// Carry is carry-out for ADD, borrow for SUB, shifted-out bit for shifts.
module alu_4bit
    import alu_ctrl_pkg::*;
(
    input  logic [DATA_W_DEF-1:0] A,
    input  logic [DATA_W_DEF-1:0] B,
    input  logic [OP_W_DEF-1:0]   opcode,
    output logic [DATA_W_DEF-1:0] results,
    output logic                  zero_flag,
    output logic                  carry_flag
);

    logic [DATA_W_DEF:0] w_add;
    logic [DATA_W_DEF:0] w_sub;

    assign w_add = {1'b0, A} + {1'b0, B};
    assign w_sub = {1'b0, A} - {1'b0, B};

    always_comb begin
        results    = '0;
        carry_flag = 1'b0;
        case (opcode)
            OP_ADD: begin
                results    = w_add[DATA_W_DEF-1:0];
                carry_flag = w_add[DATA_W_DEF];
            end
            OP_SUB: begin
                results    = w_sub[DATA_W_DEF-1:0];
                carry_flag = w_sub[DATA_W_DEF];
            end
            OP_AND: results = A & B;
            OP_OR:  results = A | B;
            OP_XOR: results = A ^ B;
            OP_NOT: results = ~A;
            OP_SHL: begin
                results    = {A[DATA_W_DEF-2:0], 1'b0};
                carry_flag = A[DATA_W_DEF-1];
            end
            OP_SHR: begin
                results    = {1'b0, A[DATA_W_DEF-1:1]};
                carry_flag = A[0];
            end
            default: begin
                results    = '0;
                carry_flag = 1'b0;
            end
        endcase
    end

    assign zero_flag = (results == '0);

endmodule

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: a lone request wins outright,
// a tie goes to the requester that did not win last time.
module rr_arbiter_2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = i_req;
        if (i_req == 2'b11) begin
            o_grant = i_last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_4bit_arbiter.sv
// Shares one external alu_4bit between two valid/ready requesters,
// holding each result in a per-requester response register.
module alu_4bit_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_A,
    input  logic [DATA_W-1:0] req0_B,
    input  logic [OP_W-1:0]   req0_opcode,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_A,
    input  logic [DATA_W-1:0] req1_B,
    input  logic [OP_W-1:0]   req1_opcode,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_results,
    output logic              rsp0_zero_flag,
    output logic              rsp0_carry_flag,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_results,
    output logic              rsp1_zero_flag,
    output logic              rsp1_carry_flag,
    output logic [DATA_W-1:0] alu_A,
    output logic [DATA_W-1:0] alu_B,
    output logic [OP_W-1:0]   alu_opcode,
    input  logic [DATA_W-1:0] alu_results,
    input  logic              alu_zero_flag,
    input  logic              alu_carry_flag,
    output logic              busy,
    output logic              grant_id
);

    state_t            r_state;
    state_t            w_next;
    logic              r_last;
    logic              r_gid;
    logic [1:0]        w_grant;
    logic              w_win_id;
    logic              w_accept;
    logic              w_rsp_hs;
    logic [DATA_W-1:0] r_A;
    logic [DATA_W-1:0] r_B;
    logic [OP_W-1:0]   r_op;
    logic              r_rsp0_valid;
    logic [DATA_W-1:0] r_rsp0_res;
    logic              r_rsp0_z;
    logic              r_rsp0_c;
    logic              r_rsp1_valid;
    logic [DATA_W-1:0] r_rsp1_res;
    logic              r_rsp1_z;
    logic              r_rsp1_c;

    rr_arbiter_2 u_arb (
        .i_req   ({req1_valid, req0_valid}),
        .i_last  (r_last),
        .o_grant (w_grant)
    );

    assign w_win_id = w_grant[1];
    assign w_accept = (r_state == ST_IDLE) && (w_grant != 2'b00);
    assign w_rsp_hs = r_gid ? (r_rsp1_valid && rsp1_ready)
                            : (r_rsp0_valid && rsp0_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_EXEC;
            ST_EXEC: w_next = ST_RESP;
            ST_RESP: if (w_rsp_hs) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req0_ready = (r_state == ST_IDLE) && w_grant[0];
        req1_ready = (r_state == ST_IDLE) && w_grant[1];
        busy       = (r_state != ST_IDLE);
    end

    // Operand regs and rsp regs only move on the FSM transitions below,
    // so they stay bit-stable through any amount of response backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last       <= 1'b1;
            r_gid        <= 1'b0;
            r_A          <= '0;
            r_B          <= '0;
            r_op         <= '0;
            r_rsp0_valid <= 1'b0;
            r_rsp0_res   <= '0;
            r_rsp0_z     <= 1'b0;
            r_rsp0_c     <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp1_res   <= '0;
            r_rsp1_z     <= 1'b0;
            r_rsp1_c     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_gid <= w_win_id;
                r_A   <= w_win_id ? req1_A : req0_A;
                r_B   <= w_win_id ? req1_B : req0_B;
                r_op  <= w_win_id ? req1_opcode : req0_opcode;
            end
            if (r_state == ST_EXEC) begin
                if (r_gid) begin
                    r_rsp1_valid <= 1'b1;
                    r_rsp1_res   <= alu_results;
                    r_rsp1_z     <= alu_zero_flag;
                    r_rsp1_c     <= alu_carry_flag;
                end else begin
                    r_rsp0_valid <= 1'b1;
                    r_rsp0_res   <= alu_results;
                    r_rsp0_z     <= alu_zero_flag;
                    r_rsp0_c     <= alu_carry_flag;
                end
            end
            if ((r_state == ST_RESP) && w_rsp_hs) begin
                r_last <= r_gid;
                if (r_gid) begin
                    r_rsp1_valid <= 1'b0;
                end else begin
                    r_rsp0_valid <= 1'b0;
                end
            end
        end
    end

    assign alu_A           = r_A;
    assign alu_B           = r_B;
    assign alu_opcode      = r_op;
    assign grant_id        = r_gid;
    assign rsp0_valid      = r_rsp0_valid;
    assign rsp0_results    = r_rsp0_res;
    assign rsp0_zero_flag  = r_rsp0_z;
    assign rsp0_carry_flag = r_rsp0_c;
    assign rsp1_valid      = r_rsp1_valid;
    assign rsp1_results    = r_rsp1_res;
    assign rsp1_zero_flag  = r_rsp1_z;
    assign rsp1_carry_flag = r_rsp1_c;

endmodule
